// File: rtl/wallace_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wallace_arb_pkg                                                   |
// | Brief  : shared types and helpers for the shared-multiplier arbiter        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package wallace_arb_pkg;

  localparam int WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic [2*WIDTH-1:0] prod_t;

  // Position of the requester that sits 'off' places after 'base' in a ring of n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wallace_mul_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arbiter                                                        |
// | Brief  : combinational round-robin pick, searching upward from a pointer   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module rr_arbiter
  import wallace_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = ID_W'(rr_wrap(int'(i_ptr), k, NUM_REQ));
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wallace_tree_reduction.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wallace_tree_reduction                                            |
// | Brief  : 5x5 unsigned combinational multiplier, carry-save reduced         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module wallace_tree_reduction (
  input  logic [4:0] A,
  input  logic [4:0] B,
  output logic [9:0] P
);

  logic [9:0] w_pp [5];
  logic [9:0] w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;

  for (genvar i = 0; i < 5; i++) begin : g_pp
    assign w_pp[i] = B[i] ? ({5'b0, A} << i) : 10'd0;
  end

  // Each 3:2 stage keeps sum+carry equal to the running total; the product
  // never reaches 1024, so the carry shifted out of bit 9 is always zero.
  assign w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
  assign w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
  assign w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
  assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;
  assign w_s3 = w_s2 ^ w_c2 ^ w_pp[4];
  assign w_c3 = ((w_s2 & w_c2) | (w_s2 & w_pp[4]) | (w_c2 & w_pp[4])) << 1;

  assign P = w_s3 + w_c3;

endmodule
`default_nettype wire

// File: rtl/wallace_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wallace_mul_arbiter                                               |
// | Brief  : round-robin sharing of one 5x5 multiplier among NUM_REQ clients   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module wallace_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [2*WIDTH-1:0]       resp_p,
  output logic [ID_W-1:0]          resp_id,
  output logic [15:0]              ops_done
);

  import wallace_arb_pkg::arb_state_t;
  import wallace_arb_pkg::prod_t;
  import wallace_arb_pkg::IDLE;
  import wallace_arb_pkg::MUL;
  import wallace_arb_pkg::RESP;

  if (WIDTH != wallace_arb_pkg::WIDTH) begin : g_bad_width
    $error("wallace_mul_arbiter: WIDTH must be 5 to match the multiplier");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("wallace_mul_arbiter: NUM_REQ must be in 2..8");
  end

  arb_state_t          r_state, w_next;
  logic [ID_W-1:0]     r_ptr, r_id, r_resp_id, w_idx;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_any;
  logic [WIDTH-1:0]    r_op_a, r_op_b, w_sel_a, w_sel_b;
  prod_t               w_prod, r_resp_p;
  logic                r_resp_valid;
  logic [15:0]         r_ops_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  wallace_tree_reduction u_mul (
    .A (r_op_a),
    .B (r_op_b),
    .P (w_prod)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == ID_W'(i)) begin
        w_sel_a = req_a[i*WIDTH +: WIDTH];
        w_sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // rst_n gating keeps grants silent while reset is held, even though the
  // state register already reads IDLE.
  assign req_ready = (rst_n && r_state == IDLE) ? w_grant : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = MUL;
      MUL:     w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_p     <= '0;
      r_resp_id    <= '0;
      r_ops_done   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_op_a <= w_sel_a;
          r_op_b <= w_sel_b;
          r_id   <= w_idx;
          r_ptr  <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
        MUL: begin
          r_resp_p     <= w_prod;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
        end
        RESP: if (resp_ready) begin
          r_resp_valid <= 1'b0;
          r_ops_done   <= r_ops_done + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_p     = r_resp_p;
  assign resp_id    = r_resp_id;
  assign ops_done   = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_wallace_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_wallace_mul_arbiter                                            |
// | Brief  : directed vector bench for the shared-multiplier arbiter           |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_wallace_mul_arbiter;

  localparam int N = 4;
  localparam int W = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic          resp_valid, resp_ready;
  logic [2*W-1:0] resp_p;
  logic [1:0]    resp_id;
  logic [15:0]   ops_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int id;
    int a;
    int b;
    int p;
  } vec_t;

  vec_t tbl [8];

  wallace_mul_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_p     (resp_p),
    .resp_id    (resp_id),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input int a, input int b);
    req_a[id*W +: W] = W'(a);
    req_b[id*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // One isolated request: grant in the valid cycle, MUL, then RESP.
  task automatic single(input string tag, input int id, input int a, input int b,
                        input int p, input int exp_cnt);
    set_op(id, a, b);
    req_valid = N'(1 << id);
    #1;
    check($sformatf("%s_ready", tag), int'(req_ready), 1 << id);
    step();
    req_valid = '0;
    check($sformatf("%s_mul_valid", tag), int'(resp_valid), 0);
    step();
    check($sformatf("%s_valid", tag), int'(resp_valid), 1);
    check($sformatf("%s_p", tag), int'(resp_p), p);
    check($sformatf("%s_id", tag), int'(resp_id), id);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check($sformatf("%s_drop", tag), int'(resp_valid), 0);
    check($sformatf("%s_cnt", tag), int'(ops_done), exp_cnt);
  endtask

  // Requesters drop valid once granted; responses consumed immediately.
  task automatic burst(input string tag, input int cnt, input int ids[4], input int ps[4]);
    int n = 0;
    int last = 0;
    int cyc = 0;
    logic [N-1:0] hs;
    resp_ready = 1'b1;
    while (n < cnt && cyc < 40) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (resp_valid) begin
        check($sformatf("%s_id%0d", tag, n), int'(resp_id), ids[n]);
        check($sformatf("%s_p%0d", tag, n), int'(resp_p), ps[n]);
        if (n > 0) check($sformatf("%s_gap%0d", tag, n), cyc - last, 3);
        last = cyc;
        n++;
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs;
      cyc++;
    end
    check($sformatf("%s_count", tag), n, cnt);
    resp_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, 22, 22, 484};
    tbl[1] = '{1, 31, 31, 961};
    tbl[2] = '{2,  0, 17,   0};
    tbl[3] = '{3, 17, 13, 221};
    tbl[4] = '{2,  1, 31,  31};
    tbl[5] = '{1, 30, 29, 870};
    tbl[6] = '{0,  5,  6,  30};
    tbl[7] = '{3, 31,  1,  31};

    // Reset state, with every requester asking while reset is held
    rst_n      = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #12;
    check("rst_ready", int'(req_ready), 0);
    check("rst_valid", int'(resp_valid), 0);
    check("rst_p", int'(resp_p), 0);
    check("rst_id", int'(resp_id), 0);
    check("rst_cnt", int'(ops_done), 0);
    req_valid  = '0;
    resp_ready = 1'b0;
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      single($sformatf("vec%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p, i + 1);

    // All four at once from pointer 0
    do_reset();
    set_op(0, 11, 31);
    set_op(1, 23, 5);
    set_op(2, 10, 14);
    set_op(3, 0, 23);
    req_valid = 4'hF;
    #1;
    check("all4_first_grant", int'(req_ready), 1);
    burst("all4", 4, '{0, 1, 2, 3}, '{341, 115, 140, 0});
    check("all4_cnt", int'(ops_done), 4);

    // Pointer moves past requester 1, so 2 beats 0
    do_reset();
    single("rr_pre", 1, 3, 4, 12, 1);
    set_op(0, 2, 3);
    set_op(2, 7, 7);
    req_valid = 4'b0101;
    #1;
    check("rr_first_grant", int'(req_ready), 4);
    burst("rr", 2, '{2, 0, 0, 0}, '{49, 6, 0, 0});

    // Backpressure with other requesters waiting
    do_reset();
    set_op(0, 31, 31);
    req_valid = 4'b0001;
    #1;
    check("bp_ready", int'(req_ready), 1);
    step();
    req_valid = 4'b1110;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), int'(resp_valid), 1);
      check($sformatf("bp_p%0d", i), int'(resp_p), 961);
      check($sformatf("bp_id%0d", i), int'(resp_id), 0);
      check($sformatf("bp_noready%0d", i), int'(req_ready), 0);
      check($sformatf("bp_cnt%0d", i), int'(ops_done), 0);
      step();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_drop", int'(resp_valid), 0);
    check("bp_cnt_final", int'(ops_done), 1);

    // Reset while in MUL discards the operation and rewinds the pointer
    do_reset();
    single("mr_pre", 1, 9, 9, 81, 1);
    set_op(2, 4, 4);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1001;
    set_op(0, 3, 7);
    set_op(3, 12, 12);
    rst_n = 1'b0;
    #1;
    check("mr_valid", int'(resp_valid), 0);
    check("mr_cnt", int'(ops_done), 0);
    check("mr_ready_in_rst", int'(req_ready), 0);
    step();
    rst_n = 1'b1;
    #1;
    check("mr_first_grant", int'(req_ready), 1);
    burst("mr", 2, '{0, 3, 0, 0}, '{21, 144, 0, 0});

    // Counter wrap from a preloaded 0xFFFF
    do_reset();
    force dut.r_ops_done = 16'hFFFF;
    step();
    release dut.r_ops_done;
    step();
    check("wrap_pre", int'(ops_done), 32'hFFFF);
    single("wrap", 0, 2, 2, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
